// File: rtl/imem_access_arbiter_if.sv
// Instruction memory access bundle: fetch read port, loader write port,
// boot hold and the byte-lane RAM port.
interface imem_access_arbiter_if #(
  parameter int AW = 9
);
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_stall;
  logic          fetch_valid;
  logic [31:0]   fetch_rdata;
  logic          fetch_err;
  logic          load_valid;
  logic [31:0]   load_addr;
  logic [31:0]   load_data;
  logic          load_ready;
  logic          load_err;
  logic          load_done;
  logic          core_hold;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    input  fetch_req, fetch_addr,
    input  load_valid, load_addr, load_data, load_done,
    input  mem_rdata,
    output fetch_stall, fetch_valid, fetch_rdata, fetch_err,
    output load_ready, load_err, core_hold,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output fetch_req, fetch_addr,
    output load_valid, load_addr, load_data, load_done,
    output mem_rdata,
    input  fetch_stall, fetch_valid, fetch_rdata, fetch_err,
    input  load_ready, load_err, core_hold,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Instruction memory port arbiter: boot-time image load, then fetch
// priority with a bounded-starvation grant for loader patch writes.
module imem_access_arbiter #(
  parameter int          MEM_DEPTH  = 2048,
  parameter int          STARVE_MAX = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic clk,
  input  logic reset,
  imem_access_arbiter_if.master bus
);
  localparam int AW = $clog2(MEM_DEPTH / 4);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   rdata_q;
  logic          valid_q;
  logic          err_q;
  logic          load_err_q;

  logic fetch_ok;
  logic load_ok;
  logic force_load;
  logic gnt_fetch;
  logic gnt_load;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(MEM_DEPTH));
  endfunction

  always_comb begin
    fetch_ok   = addr_ok(bus.fetch_addr);
    load_ok    = addr_ok(bus.load_addr);
    force_load = bus.fetch_req && bus.load_valid
              && (starve_cnt == CW'(STARVE_MAX));
    gnt_fetch  = 1'b0;
    gnt_load   = 1'b0;
    if (!reset) begin
      unique case (state)
        BOOT: gnt_load = bus.load_valid;
        RUN: begin
          gnt_load  = bus.load_valid
                   && (!bus.fetch_req || force_load);
          gnt_fetch = bus.fetch_req && !gnt_load;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      gnt_load && load_ok: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 4'hF;
        bus.mem_addr  = bus.load_addr[AW+1:2];
        bus.mem_wdata = bus.load_data;
      end
      gnt_fetch && fetch_ok: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.fetch_addr[AW+1:2];
      end
      default: ;
    endcase
  end

  assign bus.fetch_stall = reset || (state == BOOT)
                        || (bus.fetch_req && !gnt_fetch);
  assign bus.load_ready  = gnt_load;
  assign bus.load_err    = load_err_q;
  assign bus.core_hold   = (state == BOOT);
  assign bus.fetch_valid = valid_q;
  assign bus.fetch_err   = err_q;
  // RAM data lands the cycle after the read; hold it once seen.
  assign bus.fetch_rdata = (valid_q && !err_q) ? bus.mem_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      starve_cnt <= '0;
      rdata_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      if (state == BOOT && bus.load_done)
        state <= RUN;
      valid_q    <= gnt_fetch;
      err_q      <= gnt_fetch && !fetch_ok;
      load_err_q <= gnt_load && !load_ok;
      if (valid_q && !err_q)
        rdata_q <= bus.mem_rdata;
      if (gnt_fetch && !fetch_ok)
        rdata_q <= NOP_INSTR;
      if (state != RUN || !bus.load_valid || gnt_load)
        starve_cnt <= '0;
      else if (gnt_fetch)
        starve_cnt <= starve_cnt + CW'(1);
    end
  end
endmodule
